hex_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for a multi-digit 7-segment display.

---
 rtl/hex_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_hex_scan_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller sharing one hex decoder across NUM_DIGITS digits.
// Optional build macro: LEADING_ZERO_BLANK_EN darkens digits above the most significant nonzero nibble.
module hex_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 1000,
  parameter int GAP        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic                    ack,
  output logic                    frame,
  output logic [3:0]              nib,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    state_dbg
);

  localparam int CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  // Handshake: load is a one-cycle strobe that is always accepted; ack pulses
  // for one cycle at the frame boundary where the staged data becomes live.
  typedef enum logic {
    S_GAP  = 1'b0,
    S_SHOW = 1'b1
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [4*NUM_DIGITS-1:0] live_data_q;
  logic [NUM_DIGITS-1:0]   live_blank_q;
  logic [4*NUM_DIGITS-1:0] staged_data_q;
  logic [NUM_DIGITS-1:0]   staged_blank_q;
  logic                    pending_q;
  logic                    ack_q;
  logic                    frame_q;
  logic [3:0]              nib_q;
  logic [NUM_DIGITS-1:0]   dig_en_q;

  logic                    gap_done;
  logic                    show_done;
  logic                    boundary;
  logic                    transfer;
  logic [IDX_W-1:0]        idx_d;
  logic [4*NUM_DIGITS-1:0] live_data_d;
  logic [NUM_DIGITS-1:0]   live_blank_d;
  logic [NUM_DIGITS-1:0]   blank_eff;
  logic [3:0]              nib_d;
  logic [NUM_DIGITS-1:0]   show_en_d;

  assign gap_done     = (state_q == S_GAP)  && (cnt_q == CNT_W'(GAP - 1));
  assign show_done    = (state_q == S_SHOW) && (cnt_q == CNT_W'(DWELL - 1));
  assign boundary     = show_done && (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign transfer     = boundary && pending_q;
  assign idx_d        = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
  assign live_data_d  = transfer ? staged_data_q  : live_data_q;
  assign live_blank_d = transfer ? staged_blank_q : live_blank_q;

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  nz_above;

  // Walk down from the top digit; everything above the first nonzero nibble is dark.
  always_comb begin
    lz_mask  = '0;
    nz_above = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      nz_above   = nz_above | (live_data_q[4*k +: 4] != 4'h0);
      lz_mask[k] = ~nz_above;
    end
  end

  assign blank_eff = live_blank_q | lz_mask;
`else
  assign blank_eff = live_blank_q;
`endif

  always_comb begin
    nib_d     = 4'h0;
    show_en_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) nib_d = live_data_d[4*k +: 4];
      if (idx_q == IDX_W'(k)) show_en_d[k] = ~blank_eff[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_GAP;
      cnt_q          <= '0;
      idx_q          <= '0;
      live_data_q    <= '0;
      live_blank_q   <= '1;
      staged_data_q  <= '0;
      staged_blank_q <= '1;
      pending_q      <= 1'b0;
      ack_q          <= 1'b0;
      frame_q        <= 1'b0;
      nib_q          <= 4'h0;
      dig_en_q       <= '0;
    end else begin
      ack_q   <= 1'b0;
      frame_q <= 1'b0;
      case (state_q)
        S_GAP: begin
          if (gap_done) begin
            state_q  <= S_SHOW;
            cnt_q    <= '0;
            dig_en_q <= show_en_d;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_SHOW: begin
          if (show_done) begin
            state_q  <= S_GAP;
            cnt_q    <= '0;
            idx_q    <= idx_d;
            dig_en_q <= '0;
            // nib moves only here so the decoder settles during the gap.
            nib_q    <= nib_d;
            frame_q  <= boundary;
            ack_q    <= transfer;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_GAP;
          cnt_q   <= '0;
        end
      endcase

      live_data_q  <= live_data_d;
      live_blank_q <= live_blank_d;

      // A load coinciding with the boundary stays pending for the next one.
      if (load) begin
        staged_data_q  <= data_in;
        staged_blank_q <= blank_in;
        pending_q      <= 1'b1;
      end else if (boundary) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign ack       = ack_q;
  assign frame     = frame_q;
  assign nib       = nib_q;
  assign dig_en    = dig_en_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl (NUM_DIGITS=4, DWELL=4, GAP=2) against a frame-arithmetic model.
// Build with LEADING_ZERO_BLANK_EN defined to cover the leading-zero blanking variant.
module tb_hex_scan_ctrl;

  localparam int N     = 4;
  localparam int DW    = 4;
  localparam int GP    = 2;
  localparam int SLOT  = GP + DW;
  localparam int FRAME = N * SLOT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic [3:0]  blank_in = 4'h0;
  logic        ack;
  logic        frame;
  logic [3:0]  nib;
  logic [3:0]  dig_en;
  logic        state_dbg;

  hex_scan_ctrl #(.NUM_DIGITS(N), .DWELL(DW), .GAP(GP)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .data_in   (data_in),
    .blank_in  (blank_in),
    .ack       (ack),
    .frame     (frame),
    .nib       (nib),
    .dig_en    (dig_en),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t = 0;

  // Reference model: what is live/staged, in display terms.
  logic [15:0] m_live, m_staged;
  logic [3:0]  m_lblank, m_sblank;
  bit          m_pending;
  logic [3:0]  exp_en, exp_nib;
  logic        exp_ack, exp_frame, exp_state;

  // Scoreboard: the word each frame must display, compared against nibbles seen in SHOW.
  logic [15:0] exp_q[$];
  logic [15:0] obs_word;

  function automatic logic [3:0] eff_blank(input logic [15:0] d, input logic [3:0] b);
    logic [3:0] r;
    r = b;
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = 1; k < N; k++)
      if ((d >> (4 * k)) == 16'h0) r[k] = 1'b1;
`endif
    return r;
  endfunction

  function automatic void compute_expected();
    int f, slot, off;
    logic [3:0] eb;
    f    = t % FRAME;
    slot = f / SLOT;
    off  = f % SLOT;
    eb   = eff_blank(m_live, m_lblank);
    exp_nib   = m_live[4*slot +: 4];
    exp_state = (off >= GP);
    exp_en    = (exp_state && !eb[slot]) ? 4'(1 << slot) : 4'h0;
  endfunction

  task automatic model_reset();
    m_live    = 16'h0;
    m_staged  = 16'h0;
    m_lblank  = 4'hF;
    m_sblank  = 4'hF;
    m_pending = 1'b0;
    t         = 0;
    exp_ack   = 1'b0;
    exp_frame = 1'b0;
    obs_word  = 16'h0;
    exp_q.delete();
    exp_q.push_back(m_live);
    compute_expected();
  endtask

  // Driver: inputs already set for the current cycle; advance one clock and update the model.
  task automatic tick();
    logic        ld;
    logic [15:0] d, exp_w;
    logic [3:0]  b;
    int          f;
    ld = load; d = data_in; b = blank_in;
    @(posedge clk);
    #1;
    t++;
    load = 1'b0;
    f = t % FRAME;
    exp_frame = (f == 0);
    exp_ack   = 1'b0;
    if (exp_frame && m_pending) begin
      m_live    = m_staged;
      m_lblank  = m_sblank;
      m_pending = 1'b0;
      exp_ack   = 1'b1;
    end
    if (ld) begin
      m_staged  = d;
      m_sblank  = b;
      m_pending = 1'b1;
    end
    compute_expected();
    if (f == 0) exp_q.push_back(m_live);
    if (f % SLOT == GP) obs_word[4*(f/SLOT) +: 4] = nib;
    if (f == FRAME - 1 && exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (obs_word !== exp_w) begin
        errors++;
        $display("FAIL frame_word t=%0d got=%h exp=%h", t, obs_word, exp_w);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b1;
    data_in = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    load  = 1'b0;
    reset = 1'b0;
    model_reset();
    checks++;
    if ({dig_en, nib, ack, frame, state_dbg} !== {exp_en, exp_nib, exp_ack, exp_frame, exp_state}) begin
      errors++;
      $display("FAIL reset_state t=%0d got=%h exp=%h", t,
               {dig_en, nib, ack, frame, state_dbg}, {exp_en, exp_nib, exp_ack, exp_frame, exp_state});
    end
  endtask

  task automatic test_reset();
    int acks = 0;
    logic [3:0] en_or = 4'h0;
    do_reset();
    for (int c = 0; c < FRAME + 1; c++) begin
      tick();
      checks++;
      if ({dig_en, nib, ack, frame, state_dbg} !== {exp_en, exp_nib, exp_ack, exp_frame, exp_state}) begin
        errors++;
        $display("FAIL reset_frame t=%0d got=%h exp=%h", t,
                 {dig_en, nib, ack, frame, state_dbg}, {exp_en, exp_nib, exp_ack, exp_frame, exp_state});
      end
      if (ack) acks++;
      if (t < FRAME) en_or |= dig_en;
      if (t == FRAME) begin
        checks++;
        if (frame !== 1'b1) begin
          errors++;
          $display("FAIL reset_frame_pulse t=%0d got=%b exp=1", t, frame);
        end
      end
    end
    checks++;
    if (acks != 0 || en_or !== 4'h0) begin
      errors++;
      $display("FAIL reset_blank acks=%0d en_or=%b exp acks=0 en_or=0000", acks, en_or);
    end
  endtask

  task automatic test_single_load();
    int acks = 0;
    do_reset();
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (t == 5) begin load = 1'b1; data_in = 16'hA3F0; blank_in = 4'h0; end
      tick();
      checks++;
      if ({dig_en, nib, ack, frame, state_dbg} !== {exp_en, exp_nib, exp_ack, exp_frame, exp_state}) begin
        errors++;
        $display("FAIL single_load t=%0d got=%h exp=%h", t,
                 {dig_en, nib, ack, frame, state_dbg}, {exp_en, exp_nib, exp_ack, exp_frame, exp_state});
      end
      if (ack) acks++;
      if (t == FRAME + GP + SLOT) begin
        checks++;
        if ({dig_en, nib} !== {4'b0010, 4'hF}) begin
          errors++;
          $display("FAIL single_load_digit1 t=%0d got=%h exp=2f", t, {dig_en, nib});
        end
      end
    end
    checks++;
    if (acks != 1) begin
      errors++;
      $display("FAIL single_load_acks got=%0d exp=1", acks);
    end
  endtask

  task automatic test_latest_wins();
    int acks = 0;
    do_reset();
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (t == 3)  begin load = 1'b1; data_in = 16'h1234; blank_in = 4'h0; end
      if (t == 10) begin load = 1'b1; data_in = 16'h5678; blank_in = 4'h0; end
      tick();
      checks++;
      if ({dig_en, nib, ack, frame, state_dbg} !== {exp_en, exp_nib, exp_ack, exp_frame, exp_state}) begin
        errors++;
        $display("FAIL latest_wins t=%0d got=%h exp=%h", t,
                 {dig_en, nib, ack, frame, state_dbg}, {exp_en, exp_nib, exp_ack, exp_frame, exp_state});
      end
      if (ack) acks++;
    end
    checks++;
    if (acks != 1) begin
      errors++;
      $display("FAIL latest_wins_acks got=%0d exp=1", acks);
    end
  endtask

  task automatic test_blank_mask();
    logic [3:0] en_or = 4'h0;
    do_reset();
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (t == 2) begin load = 1'b1; data_in = 16'h1234; blank_in = 4'b0100; end
      tick();
      checks++;
      if ({dig_en, nib, ack, frame, state_dbg} !== {exp_en, exp_nib, exp_ack, exp_frame, exp_state}) begin
        errors++;
        $display("FAIL blank_mask t=%0d got=%h exp=%h", t,
                 {dig_en, nib, ack, frame, state_dbg}, {exp_en, exp_nib, exp_ack, exp_frame, exp_state});
      end
      if (t >= FRAME) en_or |= dig_en;
    end
    checks++;
    if (en_or !== 4'b1011) begin
      errors++;
      $display("FAIL blank_mask_union got=%b exp=1011", en_or);
    end
  endtask

  task automatic test_boundary_load();
    int acks = 0;
    do_reset();
    for (int c = 0; c < 3 * FRAME; c++) begin
      if (t == 5)         begin load = 1'b1; data_in = 16'h1111; blank_in = 4'h0; end
      if (t == FRAME - 1) begin load = 1'b1; data_in = 16'h2222; blank_in = 4'h0; end
      tick();
      checks++;
      if ({dig_en, nib, ack, frame, state_dbg} !== {exp_en, exp_nib, exp_ack, exp_frame, exp_state}) begin
        errors++;
        $display("FAIL boundary_load t=%0d got=%h exp=%h", t,
                 {dig_en, nib, ack, frame, state_dbg}, {exp_en, exp_nib, exp_ack, exp_frame, exp_state});
      end
      if (ack) acks++;
    end
    checks++;
    if (acks != 2) begin
      errors++;
      $display("FAIL boundary_load_acks got=%0d exp=2", acks);
    end
  endtask

  task automatic test_reset_mid_show();
    int acks = 0;
    logic [3:0] en_or = 4'h0;
    do_reset();
    for (int c = 0; c < FRAME + 8; c++) begin
      if (t == 1)  begin load = 1'b1; data_in = 16'h89AB; blank_in = 4'h0; end
      if (t == 26) begin load = 1'b1; data_in = 16'hCDEF; blank_in = 4'h0; end
      tick();
      checks++;
      if ({dig_en, nib, ack, frame, state_dbg} !== {exp_en, exp_nib, exp_ack, exp_frame, exp_state}) begin
        errors++;
        $display("FAIL reset_mid_pre t=%0d got=%h exp=%h", t,
                 {dig_en, nib, ack, frame, state_dbg}, {exp_en, exp_nib, exp_ack, exp_frame, exp_state});
      end
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({dig_en, nib, ack, frame, state_dbg} !== 11'h0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=000", {dig_en, nib, ack, frame, state_dbg});
    end
    do_reset();
    for (int c = 0; c < FRAME + 1; c++) begin
      tick();
      checks++;
      if ({dig_en, nib, ack, frame, state_dbg} !== {exp_en, exp_nib, exp_ack, exp_frame, exp_state}) begin
        errors++;
        $display("FAIL reset_mid_post t=%0d got=%h exp=%h", t,
                 {dig_en, nib, ack, frame, state_dbg}, {exp_en, exp_nib, exp_ack, exp_frame, exp_state});
      end
      if (ack) acks++;
      en_or |= dig_en;
    end
    checks++;
    if (acks != 0 || en_or !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid_discard acks=%0d en_or=%b exp acks=0 en_or=0000", acks, en_or);
    end
  endtask

  task automatic test_leading_zero();
    logic [3:0] or_70 = 4'h0;
    logic [3:0] or_00 = 4'h0;
    logic [3:0] want_70, want_00;
`ifdef LEADING_ZERO_BLANK_EN
    want_70 = 4'b0011;
    want_00 = 4'b0001;
`else
    want_70 = 4'b1111;
    want_00 = 4'b1111;
`endif
    do_reset();
    for (int c = 0; c < 4 * FRAME; c++) begin
      if (t == 1)         begin load = 1'b1; data_in = 16'h0070; blank_in = 4'h0; end
      if (t == 2 * FRAME) begin load = 1'b1; data_in = 16'h0000; blank_in = 4'h0; end
      tick();
      checks++;
      if ({dig_en, nib, ack, frame, state_dbg} !== {exp_en, exp_nib, exp_ack, exp_frame, exp_state}) begin
        errors++;
        $display("FAIL leading_zero t=%0d got=%h exp=%h", t,
                 {dig_en, nib, ack, frame, state_dbg}, {exp_en, exp_nib, exp_ack, exp_frame, exp_state});
      end
      if (t >= FRAME && t < 2 * FRAME) or_70 |= dig_en;
      if (t >= 3 * FRAME) or_00 |= dig_en;
    end
    checks++;
    if (or_70 !== want_70) begin
      errors++;
      $display("FAIL leading_zero_0070 got=%b exp=%b", or_70, want_70);
    end
    checks++;
    if (or_00 !== want_00) begin
      errors++;
      $display("FAIL leading_zero_0000 got=%b exp=%b", or_00, want_00);
    end
  endtask

  task automatic test_random();
    int acks = 0;
    int exp_acks = 0;
    do_reset();
    for (int c = 0; c < 10 * FRAME; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        load     = 1'b1;
        data_in  = 16'($urandom);
        blank_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      end
      tick();
      checks++;
      if ({dig_en, nib, ack, frame, state_dbg} !== {exp_en, exp_nib, exp_ack, exp_frame, exp_state}) begin
        errors++;
        $display("FAIL random t=%0d got=%h exp=%h", t,
                 {dig_en, nib, ack, frame, state_dbg}, {exp_en, exp_nib, exp_ack, exp_frame, exp_state});
      end
      if (ack) acks++;
      if (exp_ack) exp_acks++;
    end
    checks++;
    if (acks != exp_acks) begin
      errors++;
      $display("FAIL random_acks got=%0d exp=%0d", acks, exp_acks);
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_latest_wins();
    test_blank_mask();
    test_boundary_load();
    test_reset_mid_show();
    test_leading_zero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
